// File: rtl/f2f_pkg.sv
// Shared types and constants for the float-to-fixed conversion sequencer.
package f2f_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_COMPARE = 3'd2,
    S_LOAD    = 3'd3,
    S_WAIT    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam int unsigned SHIFT_LAT_DEF = 2;
  localparam logic [7:0]  BIAS_DEF      = 8'd127;
  localparam logic [7:0]  OVF_EXP_DEF   = 8'd158;

endpackage

// File: rtl/f2f_lat_counter.sv
// 4-bit loadable down-counter with a zero flag; saturates at zero.
module f2f_lat_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     count <= 4'd0;
    else if (load)                  count <= load_val;
    else if (dec && count != 4'd0)  count <= count - 4'd1;
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/float_to_fixed_seq.sv
// Sequencer for the float-to-fixed datapath: strobes the float register, loads the
// barrel shifter, waits out its latency and captures the signed fixed-point result.
module float_to_fixed_seq
  import f2f_pkg::*;
#(
  parameter int unsigned SHIFT_LAT = SHIFT_LAT_DEF,
  parameter logic [7:0]  BIAS      = BIAS_DEF,
  parameter logic [7:0]  OVF_EXP   = OVF_EXP_DEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        ACK,
  input  logic        EXP_OUT,
  input  logic [7:0]  EXP,
  input  logic [31:0] FIXED,
  output logic        EN_REG1,
  output logic        LOAD,
  output logic        MS_1,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT,
  output logic        ZERO,
  output logic        OVF
);

  state_t state;
  logic   cnt_zero;

  f2f_lat_counter u_lat_cnt (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (state == S_LOAD),
    .dec      (state == S_WAIT),
    .load_val (4'(SHIFT_LAT - 1)),
    .zero     (cnt_zero)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      EN_REG1 <= 1'b0;
      LOAD    <= 1'b0;
      MS_1    <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RESULT  <= 32'h0;
      ZERO    <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      EN_REG1 <= 1'b0;
      LOAD    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            state   <= S_CAPTURE;
            EN_REG1 <= 1'b1;
            BUSY    <= 1'b1;
          end
        end
        S_CAPTURE: state <= S_COMPARE;
        S_COMPARE: begin
          state <= S_LOAD;
          LOAD  <= 1'b1;
          // Comparator covers EXP > BIAS; the below-bias side completes EXP != BIAS.
          MS_1  <= EXP_OUT | (EXP < BIAS);
        end
        S_LOAD: state <= S_WAIT;
        S_WAIT: begin
          if (cnt_zero) begin
            state  <= S_DONE;
            BUSY   <= 1'b0;
            DONE   <= 1'b1;
            MS_1   <= 1'b0;
            RESULT <= (EXP == 8'd0) ? 32'h0 : FIXED;
            ZERO   <= (EXP == 8'd0);
            OVF    <= (EXP >= OVF_EXP);
          end
        end
        S_DONE: begin
          if (ACK) begin
            DONE <= 1'b0;
            if (START) begin
              state   <= S_CAPTURE;
              EN_REG1 <= 1'b1;
              BUSY    <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_fixed_seq.sv
// Self-checking bench for float_to_fixed_seq: cycle-level timing model plus result model.
module tb_float_to_fixed_seq;

  localparam int LAT = 2;

  logic        CLK, RST_N, START, ACK, EXP_OUT;
  logic [7:0]  EXP;
  logic [31:0] FIXED;
  logic        EN_REG1, LOAD, MS_1, BUSY, DONE, ZERO, OVF;
  logic [31:0] RESULT;

  int total = 0;
  int bad   = 0;

  float_to_fixed_seq #(.SHIFT_LAT(LAT)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ACK(ACK), .EXP_OUT(EXP_OUT),
    .EXP(EXP), .FIXED(FIXED), .EN_REG1(EN_REG1), .LOAD(LOAD), .MS_1(MS_1),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .ZERO(ZERO), .OVF(OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic begin_conv(input logic [7:0] e, input logic [31:0] f);
    EXP     = e;
    EXP_OUT = (e > 8'd127);
    FIXED   = f;
    START   = 1'b1;
    step();
    START   = 1'b0;
  endtask

  // Called just after edge E0; checks every cycle up to and including the DONE edge.
  task automatic track(input string name, input logic [7:0] e, input logic [31:0] f,
                       input bit spam);
    int en_cnt;
    logic [4:0] want, got;
    logic [31:0] want_res;
    en_cnt = 0;
    for (int k = 0; k <= LAT + 3; k++) begin
      want = {k == 0, k == 2, (k >= 2 && k < LAT + 3) && (e != 8'd127),
              k < LAT + 3, k == LAT + 3};
      got  = {EN_REG1, LOAD, MS_1, BUSY, DONE};
      en_cnt += int'(EN_REG1);
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s ctl k=%0d got={en,ld,ms,busy,done}=%b want=%b", name, k, got, want);
      end
      if (k < LAT + 3) begin
        START = spam && (k < 4);
        step();
      end
    end
    START = 1'b0;
    total++;
    if (en_cnt != 1) begin
      bad++;
      $display("FAIL %s en_reg1_pulses got=%0d want=1", name, en_cnt);
    end
    want_res = (e == 8'd0) ? 32'h0 : f;
    total++;
    if ({RESULT, ZERO, OVF} !== {want_res, e == 8'd0, e >= 8'd158}) begin
      bad++;
      $display("FAIL %s result got=%h z=%b o=%b want=%h z=%b o=%b", name, RESULT, ZERO, OVF,
               want_res, e == 8'd0, e >= 8'd158);
    end
  endtask

  task automatic ack_to_idle(input string name);
    ACK = 1'b1;
    step();
    ACK = 1'b0;
    total++;
    if ({EN_REG1, LOAD, MS_1, BUSY, DONE} !== 5'b0) begin
      bad++;
      $display("FAIL %s ack_idle got=%b want=00000", name, {EN_REG1, LOAD, MS_1, BUSY, DONE});
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; START = 0; ACK = 0; EXP = 0; EXP_OUT = 0; FIXED = 0;
    #2;
    total++;
    if ({EN_REG1, LOAD, MS_1, BUSY, DONE, ZERO, OVF, RESULT} !== 39'h0) begin
      bad++;
      $display("FAIL reset_state got=%b res=%h want all zero",
               {EN_REG1, LOAD, MS_1, BUSY, DONE, ZERO, OVF}, RESULT);
    end
    step();
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_one_point_zero();
    begin_conv(8'd127, 32'h2000_0000);
    track("one", 8'd127, 32'h2000_0000, 1'b0);
    ack_to_idle("one");
    // ACK outside DONE must do nothing
    ACK = 1'b1;
    step();
    ACK = 1'b0;
    total++;
    if ({BUSY, DONE, EN_REG1, RESULT} !== {3'b000, 32'h2000_0000}) begin
      bad++;
      $display("FAIL ack_in_idle got busy/done/en=%b res=%h want 000 20000000",
               {BUSY, DONE, EN_REG1}, RESULT);
    end
  endtask

  task automatic test_start_ignored();
    begin_conv(8'd130, 32'h0000_0140);
    track("exp130_spam", 8'd130, 32'h0000_0140, 1'b1);
    FIXED = 32'h1234_5678;
    step();
    total++;
    if ({DONE, RESULT} !== {1'b1, 32'h0000_0140}) begin
      bad++;
      $display("FAIL exp130_hold got done=%b res=%h want 1 00000140", DONE, RESULT);
    end
    ack_to_idle("exp130");
  endtask

  task automatic test_zero_and_ovf();
    begin_conv(8'd0, 32'hDEAD_BEEF);
    track("zero", 8'd0, 32'hDEAD_BEEF, 1'b0);
    ack_to_idle("zero");
    begin_conv(8'd200, 32'h7FFF_0001);
    track("ovf", 8'd200, 32'h7FFF_0001, 1'b0);
    ack_to_idle("ovf");
    begin_conv(8'd158, 32'h0000_00AA);
    track("ovf_edge", 8'd158, 32'h0000_00AA, 1'b0);
    ack_to_idle("ovf_edge");
    begin_conv(8'd157, 32'h4000_0000);
    track("below_ovf", 8'd157, 32'h4000_0000, 1'b0);
    ack_to_idle("below_ovf");
  endtask

  task automatic test_back_to_back();
    begin_conv(8'd140, 32'h0001_0000);
    track("b2b_a", 8'd140, 32'h0001_0000, 1'b0);
    EXP = 8'd100; EXP_OUT = 1'b0; FIXED = 32'h0000_0003;
    ACK = 1'b1; START = 1'b1;
    step();
    ACK = 1'b0; START = 1'b0;
    track("b2b_b", 8'd100, 32'h0000_0003, 1'b0);
    for (int i = 0; i < 10; i++) begin
      FIXED = $urandom;
      step();
      total++;
      if ({DONE, BUSY, RESULT} !== {2'b10, 32'h0000_0003}) begin
        bad++;
        $display("FAIL hold_done i=%0d got done=%b busy=%b res=%h want 1 0 00000003",
                 i, DONE, BUSY, RESULT);
      end
    end
    ack_to_idle("b2b");
  endtask

  task automatic test_reset_mid();
    begin_conv(8'd150, 32'h0BAD_F00D);
    step(); step(); step();  // now inside WAIT
    RST_N = 1'b0;
    #1;
    total++;
    if ({EN_REG1, LOAD, MS_1, BUSY, DONE, ZERO, OVF, RESULT} !== 39'h0) begin
      bad++;
      $display("FAIL reset_mid got=%b res=%h want all zero",
               {EN_REG1, LOAD, MS_1, BUSY, DONE, ZERO, OVF}, RESULT);
    end
    step();
    RST_N = 1'b1;
    for (int i = 0; i < LAT + 5; i++) begin
      step();
      total++;
      if ({BUSY, DONE} !== 2'b00) begin
        bad++;
        $display("FAIL reset_spurious i=%0d got busy/done=%b want 00", i, {BUSY, DONE});
      end
    end
    begin_conv(8'd129, 32'h0000_0004);
    track("after_reset", 8'd129, 32'h0000_0004, 1'b0);
    ack_to_idle("after_reset");
  endtask

  task automatic test_random();
    logic [7:0]  e;
    logic [31:0] f;
    for (int n = 0; n < 20; n++) begin
      e = 8'($urandom_range(0, 255));
      if (n % 5 == 0) e = 8'd0;
      f = $urandom;
      begin_conv(e, f);
      track("random", e, f, 1'b0);
      ack_to_idle("random");
    end
  endtask

  initial begin
    test_reset();
    test_one_point_zero();
    test_start_ignored();
    test_zero_and_ovf();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/float_to_fixed_seq.md
# float_to_fixed_seq

Sequencer for the float-to-fixed conversion datapath. It accepts a single-precision operand through a start/done handshake and drives the datapath controls in order: float-register strobe, shift-register load, and the exponent mux select. It waits out the barrel-shifter latency, then captures the signed fixed-point result into an output register. It sits between the system FSM / bus interface and the converter datapath, and owns every datapath control line.

## Interface
- SHIFT_LAT, 2: cycles from the LOAD pulse until the datapath FIXED output is valid; legal range 1–15.
- BIAS, 8'd127: exponent bias.
- OVF_EXP, 8'd158: exponent at or above which the result cannot be represented (flagged).

- CLK  in  1  clock, all logic on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  request; sampled only in IDLE.
- ACK  in  1  consumer acknowledges RESULT; clears DONE.
- EXP_OUT  in  1  datapath comparator output (exponent > BIAS); valid 1 cycle after the float register updates.
- EXP  in  8  datapath exponent field of the latched operand.
- FIXED  in  32  datapath fixed-point result.
- EN_REG1  out  1  float-register strobe; the datapath latches the operand on its rising edge.
- LOAD  out  1  barrel-shifter load select.
- MS_1  out  1  shift-amount select: 0 = shift by 0 (EXP == BIAS), 1 = shift by |EXP − BIAS|.
- BUSY  out  1  conversion in progress (state ≠ IDLE and ≠ DONE).
- DONE  out  1  RESULT valid; held until ACK.
- RESULT  out  32  captured fixed-point value.
- ZERO  out  1  operand exponent was 0; RESULT forced to 0.
- OVF  out  1  EXP ≥ OVF_EXP; RESULT is the datapath value, unspecified.

## Operation
- States: IDLE, CAPTURE, COMPARE, LOAD, WAIT, DONE. All outputs come from registers, so there are no combinational paths from inputs to outputs.
- IDLE: all strobes low. START=1 → CAPTURE.
- CAPTURE: EN_REG1=1 for exactly one cycle → COMPARE.
- COMPARE: all strobes low; waits for the registered EXP_OUT → LOAD.
- LOAD: LOAD=1 for exactly one cycle. MS_1 = (EXP != BIAS), held through WAIT. Counter is loaded with SHIFT_LAT−1 → WAIT.
- WAIT: counter decrements each cycle. At 0, capture into the output register and go to DONE:
  - RESULT ← (EXP==0) ? 0 : FIXED
  - ZERO ← (EXP==0)
  - OVF ← (EXP ≥ OVF_EXP)
- DONE: DONE=1; RESULT, ZERO and OVF are stable.
  - ACK=1 → IDLE.
  - ACK=1 and START=1 in the same cycle → CAPTURE. The new conversion starts and DONE drops on the next edge.
  - START alone is ignored.
- START is ignored while BUSY. No queueing.
- ACK outside DONE is ignored.
- EXP is compared as an 8-bit unsigned value. OVF and ZERO are mutually exclusive.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state = IDLE
  - EN_REG1, LOAD, MS_1, BUSY, DONE, ZERO, OVF = 0
  - RESULT = 32'h0, counter = 0
- START sampled at edge E0 → EN_REG1 high during cycle E0..E1 → LOAD high during E2..E3 → DONE rises at edge E3+SHIFT_LAT. Latency is SHIFT_LAT+3 cycles. With back-to-back ACK+START, throughput is one result per SHIFT_LAT+4 cycles.
- BUSY rises at E0 and falls on the same edge DONE rises.
- RST_N asserted mid-conversion: immediate return to IDLE, every output cleared, and no DONE pulse is produced. The datapath float register keeps stale data, which is harmless.
- MS_1 changes only on entry to LOAD and returns to 0 on entry to DONE.

## Structure
- Shared package `f2f_pkg`:
  - state enum (6 encodings, binary)
  - BIAS and OVF_EXP constants
  - SHIFT_LAT default
- One sub-module, `f2f_lat_counter`: 4-bit loadable down-counter with a zero flag, reusable by other sequencers in the codebase.
- Everything else stays in a single FSM plus output register in the top module.

## Test plan
- Operand 1.0 (EXP=127, EXP_OUT=0, FIXED model=0x20000000), START pulse → EN_REG1 one cycle, LOAD one cycle with MS_1=0, DONE at cycle SHIFT_LAT+3, RESULT=0x20000000, ZERO=OVF=0; ACK → IDLE next edge.
- Operand EXP=130 (EXP_OUT=1) → MS_1=1 during LOAD/WAIT, RESULT equals the FIXED presented at capture; START pulses in cycles 1–4 ignored, with exactly one EN_REG1 pulse.
- EXP=0 with arbitrary FIXED=0xDEADBEEF → RESULT=0, ZERO=1, OVF=0.
- EXP=200 → OVF=1, ZERO=0, DONE asserted normally.
- In DONE, ACK=1 and START=1 in the same cycle → DONE low next edge, EN_REG1 high; second result arrives SHIFT_LAT+3 later. Hold DONE 10 cycles without ACK → RESULT stable.
- RST_N low during WAIT → all outputs 0 immediately (asynchronously); after release, a new START completes with correct latency and no spurious DONE from the aborted run.
